// File: rtl/marble_launcher.sv
// ============================================================================
//  Module   : marble_launcher
//  Purpose  : Blue/red marble source for the top row of the tumble fabric.
//             Lever events from the bottom row trigger the next release;
//             interceptor capture or an empty hopper halts the run.
//  Options  : LAUNCHER_WATCHDOG_EN adds an in-flight timeout watchdog.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module marble_launcher #(
   parameter int BLUE_COUNT = 8,
   parameter int RED_COUNT  = 8,
   parameter int CNT_W      = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_start_sel,
   input  logic             i_reload,
   input  logic             i_lever_left,
   input  logic             i_lever_right,
   input  logic             i_intercept,
   output logic             o_left,
   output logic             o_right,
   output logic [CNT_W-1:0] o_blue_cnt,
   output logic [CNT_W-1:0] o_red_cnt,
   output logic             o_busy,
   output logic             o_halted,
   output logic             o_empty,
   output logic             o_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_FLIGHT = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] BLUE_INIT = CNT_W'(BLUE_COUNT);
   localparam logic [CNT_W-1:0] RED_INIT  = CNT_W'(RED_COUNT);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] blue_cnt, blue_nxt;
   logic [CNT_W-1:0] red_cnt, red_nxt;
   logic             left_pulse, left_nxt;
   logic             right_pulse, right_nxt;
   logic             busy, halted;
   logic             empty_flag, empty_nxt;
   logic             launch_req, launch_red;
   logic             wdog_expired;
   logic             any_event;

   assign any_event = i_intercept | i_lever_left | i_lever_right;

   always_comb begin
      state_nxt  = state;
      blue_nxt   = blue_cnt;
      red_nxt    = red_cnt;
      left_nxt   = 1'b0;
      right_nxt  = 1'b0;
      empty_nxt  = empty_flag;
      launch_req = 1'b0;
      launch_red = 1'b0;

      if (i_reload) begin
         state_nxt = ST_IDLE;
         blue_nxt  = BLUE_INIT;
         red_nxt   = RED_INIT;
         empty_nxt = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  launch_req = 1'b1;
                  launch_red = i_start_sel;
               end
            end
            ST_LAUNCH: state_nxt = ST_FLIGHT;
            ST_FLIGHT: begin
               // Intercept beats both levers; left lever beats right.
               if (i_intercept) begin
                  state_nxt = ST_HALT;
               end else if (i_lever_left) begin
                  launch_req = 1'b1;
               end else if (i_lever_right) begin
                  launch_req = 1'b1;
                  launch_red = 1'b1;
               end else if (wdog_expired) begin
                  state_nxt = ST_HALT;
               end
            end
            default: state_nxt = ST_HALT;
         endcase

         if (launch_req) begin
            if (!launch_red && blue_cnt != '0) begin
               state_nxt = ST_LAUNCH;
               left_nxt  = 1'b1;
               blue_nxt  = blue_cnt - 1'b1;
            end else if (launch_red && red_cnt != '0) begin
               state_nxt = ST_LAUNCH;
               right_nxt = 1'b1;
               red_nxt   = red_cnt - 1'b1;
            end else begin
               state_nxt = ST_HALT;
               empty_nxt = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         blue_cnt    <= BLUE_INIT;
         red_cnt     <= RED_INIT;
         left_pulse  <= 1'b0;
         right_pulse <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         empty_flag  <= 1'b0;
      end else begin
         state       <= state_nxt;
         blue_cnt    <= blue_nxt;
         red_cnt     <= red_nxt;
         left_pulse  <= left_nxt;
         right_pulse <= right_nxt;
         busy        <= (state_nxt == ST_LAUNCH) || (state_nxt == ST_FLIGHT);
         halted      <= (state_nxt == ST_HALT);
         empty_flag  <= empty_nxt;
      end
   end

`ifdef LAUNCHER_WATCHDOG_EN
   localparam int FC_W = $clog2(TIMEOUT + 1);

   logic [FC_W-1:0] flight_cnt;
   logic            timeout_flag;

   // Counter reads zero in the first FLIGHT cycle, so TIMEOUT-1 marks the last one.
   assign wdog_expired = (flight_cnt == FC_W'(TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || i_reload) begin
         flight_cnt   <= '0;
         timeout_flag <= 1'b0;
      end else begin
         flight_cnt <= (state == ST_FLIGHT) ? flight_cnt + 1'b1 : '0;
         if (state == ST_FLIGHT && !any_event && wdog_expired)
            timeout_flag <= 1'b1;
      end
   end

   assign o_timeout = timeout_flag;
`else
   // Watchdog compiled out: expiry is a constant false for any legal TIMEOUT.
   assign wdog_expired = (TIMEOUT < 0) && any_event;
   assign o_timeout    = 1'b0;
`endif

   assign o_left     = left_pulse;
   assign o_right    = right_pulse;
   assign o_blue_cnt = blue_cnt;
   assign o_red_cnt  = red_cnt;
   assign o_busy     = busy;
   assign o_halted   = halted;
   assign o_empty    = empty_flag;

endmodule

`default_nettype wire

// File: tb/tb_marble_launcher.sv
// ============================================================================
//  Module   : tb_marble_launcher
//  Purpose  : Directed plus randomized bench for marble_launcher against a
//             behavioural hopper/run model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_marble_launcher;

   localparam int B_CNT = 8;
   localparam int R_CNT = 8;
   localparam int W     = 4;
`ifdef LAUNCHER_WATCHDOG_EN
   localparam int TO = 10;
`else
   localparam int TO = 255;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b0, start = 1'b0, start_sel = 1'b0, reload = 1'b0;
   logic         lever_left = 1'b0, lever_right = 1'b0, intercept = 1'b0;
   logic         left, right, busy, halted, empty, timeout;
   logic [W-1:0] blue_cnt, red_cnt;

   marble_launcher #(
      .BLUE_COUNT(B_CNT), .RED_COUNT(R_CNT), .CNT_W(W), .TIMEOUT(TO)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_start_sel(start_sel),
      .i_reload(reload), .i_lever_left(lever_left), .i_lever_right(lever_right),
      .i_intercept(intercept), .o_left(left), .o_right(right),
      .o_blue_cnt(blue_cnt), .o_red_cnt(red_cnt), .o_busy(busy),
      .o_halted(halted), .o_empty(empty), .o_timeout(timeout)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: run phase, hopper contents and flags.
   localparam int P_IDLE = 0, P_LAUNCH = 1, P_FLIGHT = 2, P_HALT = 3;
   int m_phase = P_IDLE;
   int m_blue  = B_CNT;
   int m_red   = R_CNT;
   bit m_left, m_right, m_empty, m_to;
`ifdef LAUNCHER_WATCHDOG_EN
   int m_fl = 0;
`endif

   task automatic model_release(input bit red);
      if (!red && m_blue > 0) begin
         m_blue--; m_left = 1; m_phase = P_LAUNCH;
      end else if (red && m_red > 0) begin
         m_red--; m_right = 1; m_phase = P_LAUNCH;
      end else begin
         m_phase = P_HALT; m_empty = 1;
      end
   endtask

   task automatic model_step();
      m_left  = 0;
      m_right = 0;
      if (rst || reload) begin
         m_phase = P_IDLE; m_blue = B_CNT; m_red = R_CNT; m_empty = 0; m_to = 0;
      end else begin
         case (m_phase)
            P_IDLE:   if (start) model_release(start_sel);
            P_LAUNCH: begin
               m_phase = P_FLIGHT;
`ifdef LAUNCHER_WATCHDOG_EN
               m_fl = 0;
`endif
            end
            P_FLIGHT: begin
               if (intercept)        m_phase = P_HALT;
               else if (lever_left)  model_release(0);
               else if (lever_right) model_release(1);
               else begin
`ifdef LAUNCHER_WATCHDOG_EN
                  m_fl++;
                  if (m_fl >= TO) begin
                     m_phase = P_HALT; m_to = 1;
                  end
`endif
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic compare_all();
      check("left",    left,     m_left);
      check("right",   right,    m_right);
      check("blue",    blue_cnt, m_blue);
      check("red",     red_cnt,  m_red);
      check("busy",    busy,     (m_phase == P_LAUNCH || m_phase == P_FLIGHT));
      check("halted",  halted,   (m_phase == P_HALT));
      check("empty",   empty,    m_empty);
      check("timeout", timeout,  m_to);
   endtask

   // Apply one cycle of inputs, advance the model on the edge, compare after it.
   task automatic cycle(input bit st, input bit sel, input bit rl,
                        input bit ll, input bit lr, input bit ic);
      start = st; start_sel = sel; reload = rl;
      lever_left = ll; lever_right = lr; intercept = ic;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      start = 0; start_sel = 0; reload = 0;
      lever_left = 0; lever_right = 0; intercept = 0; rst = 0;
   endtask

   initial begin
      #2;
      rst = 1;
      cycle(0, 0, 0, 0, 0, 0);
      check("rst_blue", blue_cnt, 8);
      check("rst_busy", busy, 0);

      // Blue start: pulse plus decrement in the next cycle.
      cycle(1, 0, 0, 0, 0, 0);
      check("tp_left", left, 1);
      check("tp_blue", blue_cnt, 7);
      check("tp_busy", busy, 1);
      cycle(0, 0, 0, 0, 0, 0);
      check("tp_left_one", left, 0);

      // Drain the red hopper through the right lever.
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 0, 0, 1, 0);
         check("drain_right", right, 1);
         cycle(0, 0, 0, 0, 0, 0);
      end
      check("red_zero", red_cnt, 0);
      cycle(0, 0, 0, 0, 1, 0);
      check("empty_halt", halted, 1);
      check("empty_flag", empty, 1);
      check("empty_nopulse", right, 0);

      cycle(0, 0, 1, 0, 0, 0);
      check("reload_blue", blue_cnt, 8);
      check("reload_red", red_cnt, 8);
      check("reload_empty", empty, 0);

      // Intercept beats a simultaneous lever; start is ignored in HALT.
      cycle(1, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 1);
      check("icpt_halt", halted, 1);
      check("icpt_noleft", left, 0);
      check("icpt_blue", blue_cnt, 8);
      cycle(1, 0, 0, 0, 0, 0);
      check("halt_ignores_start", left, 0);

      // Both levers together: left wins, red untouched.
      cycle(0, 0, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 1, 0);
      check("both_left", left, 1);
      check("both_right", right, 0);
      check("both_red", red_cnt, 8);
      check("both_blue", blue_cnt, 6);

      // Long flight with no events.
      for (int i = 0; i < 1000; i++) cycle(0, 0, 0, 0, 0, 0);
`ifdef LAUNCHER_WATCHDOG_EN
      check("wd_timeout", timeout, 1);
      check("wd_halted", halted, 1);
`else
      check("wd_timeout", timeout, 0);
      check("wd_busy", busy, 1);
`endif

      // Randomized traffic.
      cycle(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
